// File: rtl/ps2_key_ascii_pkg.sv
// Shared constants for the PS/2 keyboard front end:
// ASCII codes, scancodes and receiver state encoding.
package ps2_key_ascii_pkg;

  localparam logic [7:0] KEY_A  = 8'h61;
  localparam logic [7:0] KEY_D  = 8'h64;
  localparam logic [7:0] KEY_W  = 8'h77;
  localparam logic [7:0] KEY_S  = 8'h73;
  localparam logic [7:0] KEY_J  = 8'h6A;
  localparam logic [7:0] KEY_SP = 8'h20;

  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_J     = 8'h3B;
  localparam logic [7:0] SC_SP    = 8'h29;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [1:0] RX_IDLE   = 2'd0;
  localparam logic [1:0] RX_SHIFT  = 2'd1;
  localparam logic [1:0] RX_PARITY = 2'd2;
  localparam logic [1:0] RX_STOP   = 2'd3;

endpackage

// File: rtl/ps2_key_ascii_rx.sv
// PS/2 frame receiver: pin sync, falling-edge detect,
// start/data/parity/stop checking and mid-frame timeout.
module ps2_rx
  import ps2_key_ascii_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_vld,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC);
  localparam int MS = SYNC_STAGES - 1;

  logic [MS:0]   cs;
  logic [MS:0]   ds;
  logic          cprev;
  logic          fall;
  logic          bit_in;
  logic          tout;
  logic [1:0]    state;
  logic [2:0]    bcnt;
  logic [7:0]    sh;
  logic          par;
  logic [TW-1:0] tcnt;

  assign fall   = cprev & ~cs[MS];
  assign bit_in = ds[MS];
  // An edge in the same cycle restarts the window, so it wins.
  assign tout   = !fall && (state != RX_IDLE) && (tcnt == TLIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      cs    <= '1;
      ds    <= '1;
      cprev <= 1'b1;
    end else begin
      cs    <= {cs[MS-1:0], ps2_clk};
      ds    <= {ds[MS-1:0], ps2_data};
      cprev <= cs[MS];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RX_IDLE;
      bcnt      <= '0;
      sh        <= '0;
      par       <= 1'b0;
      tcnt      <= '0;
      rx_byte   <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      if (fall)
        tcnt <= '0;
      else if (tcnt != TLIM)
        tcnt <= tcnt + 1'b1;
      if (tout) begin
        frame_err <= 1'b1;
        state     <= RX_IDLE;
      end else if (fall) begin
        case (state)
          RX_IDLE: begin
            bcnt <= '0;
            if (!bit_in)
              state <= RX_SHIFT;
          end
          RX_SHIFT: begin
            sh   <= {bit_in, sh[7:1]};
            bcnt <= bcnt + 1'b1;
            if (bcnt == 3'd7)
              state <= RX_PARITY;
          end
          RX_PARITY: begin
            par   <= bit_in;
            state <= RX_STOP;
          end
          default: begin
            if (bit_in && (^{sh, par})) begin
              rx_byte  <= sh;
              byte_vld <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= RX_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_key_ascii.sv
// PS/2 keyboard front end: prefix tracking and game-key
// scancode to ASCII mapping with held-key press output.
module ps2_key_ascii
  import ps2_key_ascii_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ascii,
  output logic       press,
  output logic       key_stb,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       byte_vld;
  logic       ext;
  logic       brk;
  logic [7:0] map_asc;
  logic       map_hit;

  ps2_rx #(
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_vld  (byte_vld),
    .frame_err (frame_err)
  );

  always_comb begin
    map_asc = 8'h00;
    map_hit = 1'b1;
    case (rx_byte)
      SC_A:    map_asc = KEY_A;
      SC_D:    map_asc = KEY_D;
      SC_W:    map_asc = KEY_W;
      SC_S:    map_asc = KEY_S;
      SC_J:    map_asc = KEY_J;
      SC_SP:   map_asc = KEY_SP;
      default: map_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext     <= 1'b0;
      brk     <= 1'b0;
      ascii   <= 8'h00;
      press   <= 1'b0;
      key_stb <= 1'b0;
    end else begin
      key_stb <= 1'b0;
      if (byte_vld) begin
        if (rx_byte == SC_EXT) begin
          ext <= 1'b1;
        end else if (rx_byte == SC_BREAK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          // Extended codes share scancodes with game keys; drop them.
          if (!ext && map_hit) begin
            if (brk) begin
              if (map_asc == ascii)
                press <= 1'b0;
            end else begin
              ascii   <= map_asc;
              press   <= 1'b1;
              key_stb <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
